// File: rtl/m_mem_loader.sv
// Byte-stream loader for the M memory: packs bytes little-endian into words, writes them
// through the B port, then hands off to ShortestPath_4. Optional LOADER_CHECKSUM_EN adds a byte sum.
module m_mem_loader #(
  parameter int unsigned A_INIT_WIDTH = 11,
  parameter int unsigned D_INIT_WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic [7:0]              In_Data,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [A_INIT_WIDTH-1:0] M_Addr_B,
  output logic [D_INIT_WIDTH-1:0] M_Out_B,
  output logic                    M_En_B,
  output logic                    M_We_B,
  output logic                    Go,
  input  logic                    Done,
  output logic                    Busy,
  output logic                    Finished,
  output logic [7:0]              Checksum
);

  localparam int unsigned BPW  = D_INIT_WIDTH / 8;
  localparam int unsigned BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BC_W-1:0]         LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [A_INIT_WIDTH-1:0] LAST_WORD = {A_INIT_WIDTH{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_GO    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]              state;
  logic [2:0]              state_next;
  logic [A_INIT_WIDTH-1:0] word_cnt;
  logic [BC_W-1:0]         byte_cnt;
  logic [D_INIT_WIDTH-1:0] pack;
  logic [D_INIT_WIDTH-1:0] word_c;
  logic                    accept_c;
  logic                    word_done_c;
  logic                    load_start_c;

  // In_Ready is only ever high in LOAD, so acceptance implies LOAD
  assign accept_c     = In_Valid && In_Ready;
  assign word_done_c  = accept_c && (byte_cnt == LAST_BYTE);
  assign load_start_c = (state == S_IDLE) && Start;

  // Current pack register with the incoming byte merged into its lane
  always_comb begin
    word_c = pack;
    word_c[{byte_cnt, 3'b000} +: 8] = In_Data;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_LOAD;
      S_LOAD:  if (word_done_c && (word_cnt == LAST_WORD)) state_next = S_FLUSH;
      S_FLUSH: state_next = S_GO;
      S_GO:    state_next = S_WAIT;
      S_WAIT:  if (Done) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the state exactly
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      In_Ready <= 1'b0;
      Busy     <= 1'b0;
      Go       <= 1'b0;
      Finished <= 1'b0;
    end else begin
      In_Ready <= (state_next == S_LOAD);
      Busy     <= (state_next != S_IDLE);
      Go       <= (state_next == S_GO);
      Finished <= (state_next == S_FIN);
    end
  end

  // Packing and pipelined B-port write; the write overlaps acceptance of the next byte
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      pack     <= '0;
      M_Addr_B <= '0;
      M_Out_B  <= '0;
      M_En_B   <= 1'b0;
      M_We_B   <= 1'b0;
    end else begin
      M_En_B <= 1'b0;
      M_We_B <= 1'b0;
      if (load_start_c) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        pack     <= '0;
      end else if (accept_c) begin
        pack <= word_c;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          M_En_B   <= 1'b1;
          M_We_B   <= 1'b1;
          M_Addr_B <= word_cnt;
          M_Out_B  <= word_c;
          if (word_cnt != LAST_WORD) word_cnt <= word_cnt + A_INIT_WIDTH'(1);
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Modulo-256 sum of accepted bytes; holds once LOAD ends
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)               Checksum <= 8'h00;
    else if (load_start_c) Checksum <= 8'h00;
    else if (accept_c)     Checksum <= Checksum + In_Data;
  end
`else
  assign Checksum = 8'h00;
`endif

endmodule

// File: tb/tb_m_mem_loader.sv
// Self-checking bench for m_mem_loader: directed load scenarios with random data and
// random valid gaps, compared against a byte-level memory model.
module tb_m_mem_loader;

  localparam int unsigned NWORDS = 2048;
  localparam int unsigned NBYTES = NWORDS * 4;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [7:0]  In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [10:0] M_Addr_B;
  logic [31:0] M_Out_B;
  logic        M_En_B;
  logic        M_We_B;
  logic        Go;
  logic        Done;
  logic        Busy;
  logic        Finished;
  logic [7:0]  Checksum;

  m_mem_loader #(.A_INIT_WIDTH(11), .D_INIT_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .M_Addr_B(M_Addr_B), .M_Out_B(M_Out_B), .M_En_B(M_En_B),
    .M_We_B(M_We_B), .Go(Go), .Done(Done), .Busy(Busy), .Finished(Finished),
    .Checksum(Checksum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [NWORDS];
  logic [7:0]  src [NBYTES];
  int cyc = 0;
  int wr_cnt, go_cnt, last_wr_cyc, go_cyc;
  bit bad_order, ready_drop, busy_drop;

  always @(posedge Clk) cyc++;

  // Behaves as the M memory B port and logs write/Go timing
  always @(negedge Clk) begin
    if (M_En_B && M_We_B) begin
      if (M_Addr_B !== 11'(wr_cnt)) bad_order = 1'b1;
      mem[M_Addr_B] = M_Out_B;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (Go) begin
      go_cnt++;
      go_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int mode, input int n);
    case (mode)
      0:       return 8'(n);
      1:       return 8'($urandom);
      2:       return 8'h01;
      default: return (n == NBYTES - 1) ? 8'h05 : 8'h01;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    return 32'(src[4*i]) + 32'(src[4*i+1]) * 256 + 32'(src[4*i+2]) * 65536
         + 32'(src[4*i+3]) * 16777216;
  endfunction

  function automatic logic [7:0] exp_sum(input int nbytes);
    int s = 0;
    for (int i = 0; i < nbytes; i++) s += int'(src[i]);
`ifdef LOADER_CHECKSUM_EN
    return 8'(s);
`else
    return 8'(s & 0);
`endif
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < NBYTES; i++) src[i] = gen(mode, i);
  endtask

  task automatic begin_load();
    for (int i = 0; i < NWORDS; i++) mem[i] = 'x;
    wr_cnt = 0; go_cnt = 0; bad_order = 1'b0; ready_drop = 1'b0;
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  // Offers bytes until nbytes are accepted; optionally pokes Start mid-load
  task automatic send(input int nbytes, input bit gaps, input bit poke);
    int n = 0;
    int guard = 0;
    while (n < nbytes && guard < 40000) begin
      guard++;
      @(posedge Clk); #1;
      Start = poke && (n == 3000);
      if (gaps && $urandom_range(1) == 0) begin
        In_Valid = 1'b0;
        In_Data  = 8'($urandom);
      end else begin
        In_Valid = 1'b1;
        In_Data  = src[n];
      end
      @(negedge Clk);
      if (!In_Ready) ready_drop = 1'b1;
      if (In_Valid && In_Ready) n++;
    end
    check("bytes_accepted", n, nbytes);
  endtask

  task automatic full_load(input string tag, input bit gaps, input bit poke);
    int mism = 0;
    begin_load();
    send(NBYTES, gaps, poke);
    @(posedge Clk); #1 In_Valid = 1'b0; Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (go_cnt != 0) break;
    end
    check({tag, "_go_count"}, go_cnt, 1);
    check({tag, "_write_count"}, wr_cnt, NWORDS);
    check({tag, "_go_latency"}, go_cyc - last_wr_cyc, 1);
    check({tag, "_addr_order"}, 32'(bad_order), 0);
    check({tag, "_ready_in_load"}, 32'(ready_drop), 0);
    for (int i = 0; i < NWORDS; i++) if (mem[i] !== exp_word(i)) mism++;
    check({tag, "_mem_mismatches"}, mism, 0);
    check({tag, "_word0"}, mem[0], exp_word(0));
    check({tag, "_checksum"}, 32'(Checksum), 32'(exp_sum(NBYTES)));
  endtask

  // WAIT phase: Busy must hold, Start ignored, Finished pulses once after Done
  task automatic finish_load(input string tag, input int hold, input bit poke);
    busy_drop = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1 Start = poke && (i == 10);
      @(negedge Clk);
      if (!Busy || In_Ready || Finished) busy_drop = 1'b1;
    end
    @(posedge Clk); #1 Start = 1'b0; Done = 1'b1;
    @(negedge Clk);
    check({tag, "_fin_early"}, 32'(Finished), 0);
    check({tag, "_busy_wait"}, 32'(busy_drop), 0);
    @(posedge Clk); #1 Done = 1'b0;
    @(negedge Clk);
    check({tag, "_fin_pulse"}, 32'(Finished), 1);
    check({tag, "_busy_fin"}, 32'(Busy), 1);
    @(negedge Clk);
    check({tag, "_fin_end"}, 32'(Finished), 0);
    check({tag, "_idle_busy"}, 32'(Busy), 0);
    check({tag, "_single_go"}, go_cnt, 1);
    check({tag, "_no_extra_write"}, wr_cnt, NWORDS);
    check({tag, "_checksum_held"}, 32'(Checksum), 32'(exp_sum(NBYTES)));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 32'(In_Ready), 0);
    check({tag, "_addr"}, 32'(M_Addr_B), 0);
    check({tag, "_data"}, M_Out_B, 0);
    check({tag, "_en_we"}, {30'd0, M_En_B, M_We_B}, 0);
    check({tag, "_go"}, 32'(Go), 0);
    check({tag, "_busy_fin"}, {30'd0, Busy, Finished}, 0);
    check({tag, "_checksum"}, 32'(Checksum), 0);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; In_Data = 8'h00; In_Valid = 1'b0; Done = 1'b0;
    wr_cnt = 0; go_cnt = 0; last_wr_cyc = 0; go_cyc = 0;
    bad_order = 1'b0; ready_drop = 1'b0; busy_drop = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check_outputs_zero("reset");
    Rst = 1'b0;

    // Continuous stream n mod 256, Start poked during LOAD and WAIT
    fill(0);
    full_load("seq", 1'b0, 1'b1);
    check("seq_word1", mem[1], 32'h07060504);
    check("seq_word0_const", mem[0], 32'h03020100);
    check("seq_word2047", mem[2047], 32'hFFFEFDFC);
    finish_load("seq", 20, 1'b1);

    // Same data with random valid gaps
    full_load("gaps", 1'b1, 1'b0);
    finish_load("gaps", 500, 1'b0);

    // Reset after 1001 accepted bytes
    fill(1);
    begin_load();
    send(1001, 1'b0, 1'b0);
    @(posedge Clk); #1 In_Valid = 1'b0;
    #1 Rst = 1'b1;
    #1 check_outputs_zero("midrst");
    repeat (4) @(posedge Clk);
    #1 check("midrst_writes", wr_cnt, 250);
    check("midrst_no_write", {30'd0, M_En_B, M_We_B}, 0);
    Rst = 1'b0;

    // Fresh random stream after reset must start at word 0
    fill(1);
    full_load("reload", 1'b0, 1'b0);
    finish_load("reload", 5, 1'b0);

    fill(2);
    full_load("ones", 1'b0, 1'b0);
    finish_load("ones", 5, 1'b0);

    fill(3);
    full_load("ones5", 1'b0, 1'b0);
    finish_load("ones5", 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
